// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared types and constants for the dino-runner obstacle logic.
//   obstacle_kind_e : kind of obstacle handed to the object slots
//   spawner_state_e : obstacle_spawner FSM states
//   DEFAULT_MIN_GAP / DEFAULT_GAP_FLOOR : default gap timing, in frame ticks
// -----------------------------------------------------------------------------
package dino_pkg;

  typedef enum logic [1:0] {
    SMALL  = 2'd0,
    TALL   = 2'd1,
    DOUBLE = 2'd2,
    BIRD   = 2'd3
  } obstacle_kind_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    REQ  = 2'd3
  } spawner_state_e;

  localparam int DEFAULT_MIN_GAP   = 8;
  localparam int DEFAULT_GAP_FLOOR = 4;

endpackage

// File: rtl/spawn_gap_calc.sv
// -----------------------------------------------------------------------------
// spawn_gap_calc
// Purely combinational: turns one RNG sample and the difficulty level into the
// next inter-obstacle gap and obstacle kind.
//   rnd   in  5       RNG sample (bits [3:0] jitter the gap, {4,0} pick kind)
//   level in  2       difficulty; each step shortens the gap by two ticks
//   gap   out GAP_W   MIN_GAP + rnd[3:0] - 2*level, clamped to GAP_FLOOR
//   kind  out 2       obstacle kind
// Configuration macro OBSTACLE_BIRD_EN: when undefined, a computed BIRD is
// replaced by SMALL so birds never appear.
// -----------------------------------------------------------------------------
module spawn_gap_calc
  import dino_pkg::*;
#(
  parameter int MIN_GAP   = DEFAULT_MIN_GAP,
  parameter int GAP_FLOOR = DEFAULT_GAP_FLOOR,
  parameter int GAP_W     = 6
) (
  input  logic [4:0]       rnd,
  input  logic [1:0]       level,
  output logic [GAP_W-1:0] gap,
  output obstacle_kind_e   kind
);

  // Evaluated as a signed int so a high level cannot wrap the subtraction
  // before the floor is applied.
  function automatic logic [GAP_W-1:0] clamp_gap(input logic [3:0] jitter,
                                                 input logic [1:0] lvl);
    int raw;
    raw = MIN_GAP + int'(jitter) - 2 * int'(lvl);
    if (raw < GAP_FLOOR) raw = GAP_FLOOR;
    return raw[GAP_W-1:0];
  endfunction

  always_comb begin
    gap  = clamp_gap(rnd[3:0], level);
    kind = obstacle_kind_e'({rnd[4], rnd[0]});
`ifndef OBSTACLE_BIRD_EN
    if (kind == BIRD) kind = SMALL;
`endif
  end

endmodule

// File: rtl/obstacle_spawner.sv
// -----------------------------------------------------------------------------
// obstacle_spawner
// Paces obstacle spawns: after each load it counts down a random gap of frame
// ticks, then holds a spawn request until an object slot accepts it.
//   clk          in  1  system clock, rising edge
//   rst          in  1  asynchronous active-high reset
//   tick         in  1  one-cycle frame-tick pulse
//   run          in  1  game active; 0 pauses and abandons any pending request
//   rnd          in  5  RNG sample, read only in the LOAD cycle
//   level        in  2  difficulty level 0..3
//   spawn_ack    in  1  slot accepted the current request (only seen in REQ)
//   spawn_req    out 1  spawn request, high while in REQ
//   spawn_kind   out 2  kind of the pending obstacle; 0 when no request
//   spawn_count  out 8  saturating count of accepted spawns, cleared by rst only
// Configuration macro OBSTACLE_BIRD_EN (see spawn_gap_calc).
// -----------------------------------------------------------------------------
module obstacle_spawner
  import dino_pkg::*;
#(
  parameter int MIN_GAP   = DEFAULT_MIN_GAP,
  parameter int GAP_FLOOR = DEFAULT_GAP_FLOOR,
  parameter int GAP_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  input  logic [4:0] rnd,
  input  logic [1:0] level,
  input  logic       spawn_ack,
  output logic       spawn_req,
  output logic [1:0] spawn_kind,
  output logic [7:0] spawn_count
);

  spawner_state_e   state, state_next;
  logic [GAP_W-1:0] gap_cnt;
  obstacle_kind_e   kind_q;
  logic [7:0]       count_q;

  logic [GAP_W-1:0] gap_calc;
  obstacle_kind_e   kind_calc;

  spawn_gap_calc #(
    .MIN_GAP  (MIN_GAP),
    .GAP_FLOOR(GAP_FLOOR),
    .GAP_W    (GAP_W)
  ) u_gap_calc (
    .rnd  (rnd),
    .level(level),
    .gap  (gap_calc),
    .kind (kind_calc)
  );

  wire last_tick = tick && (gap_cnt == GAP_W'(1));
  wire accepted  = (state == REQ) && spawn_ack;

  // NOTE: the async reset sits in the sensitivity list so outputs clear the
  // instant rst rises, not at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assigned first so every path drives state_next (no latch).
  always_comb begin
    state_next = state;
    if (!run) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: state_next = LOAD;
        LOAD: state_next = WAIT;
        WAIT: if (last_tick) state_next = REQ;
        REQ:  if (spawn_ack) state_next = LOAD;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
      kind_q  <= SMALL;
      count_q <= '0;
    end else begin
      // An ack in REQ counts even when run drops in the same cycle.
      if (accepted && (count_q != 8'hFF)) count_q <= count_q + 8'd1;

      if (!run) begin
        gap_cnt <= '0;
      end else begin
        unique case (state)
          LOAD: begin
            gap_cnt <= gap_calc;
            kind_q  <= kind_calc;
          end
          WAIT:    if (tick) gap_cnt <= gap_cnt - GAP_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign spawn_req   = (state == REQ);
  assign spawn_kind  = (state == REQ) ? kind_q : SMALL;
  assign spawn_count = count_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// -----------------------------------------------------------------------------
// tb_obstacle_spawner
// Directed tests for obstacle_spawner with hand-computed gaps and kinds.
// Honours OBSTACLE_BIRD_EN for the expected kind of rnd=5'b10011.
// -----------------------------------------------------------------------------
module tb_obstacle_spawner;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       run;
  logic [4:0] rnd;
  logic [1:0] level;
  logic       spawn_ack;
  logic       spawn_req;
  logic [1:0] spawn_kind;
  logic [7:0] spawn_count;

  int checks   = 0;
  int failures = 0;

`ifdef OBSTACLE_BIRD_EN
  localparam logic [1:0] KIND_10011 = 2'd3;
`else
  localparam logic [1:0] KIND_10011 = 2'd0;
`endif

  always #5 clk = ~clk;

  obstacle_spawner dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .run        (run),
    .rnd        (rnd),
    .level      (level),
    .spawn_ack  (spawn_ack),
    .spawn_req  (spawn_req),
    .spawn_kind (spawn_kind),
    .spawn_count(spawn_count)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Reset, then run=1 with the given sample: first edge IDLE->LOAD, second
  // edge loads the gap. Returns with the spawner in WAIT.
  task automatic start(input logic [4:0] r, input logic [1:0] l);
    rst = 1'b1; run = 1'b0; tick = 1'b0; spawn_ack = 1'b0;
    step();
    rst = 1'b0; rnd = r; level = l; run = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; tick = 1'b0; spawn_ack = 1'b0; rnd = 5'd0; level = 2'd0;
    #3;
    checks++;
    if ({spawn_req, spawn_kind, spawn_count} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b kind=%0d count=%0d, required all 0",
               spawn_req, spawn_kind, spawn_count);
    end
    step();
    rst = 1'b0;
    repeat (3) pulse_tick();
    checks++;
    if (spawn_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: req=%b, required 0", spawn_req);
    end
  endtask

  // gap = 8 + 3 - 0 = 11; rnd changes during WAIT must not matter.
  task automatic test_gap_basic();
    start(5'b10011, 2'd0);
    for (int i = 1; i <= 11; i++) begin
      if (i == 5) rnd = 5'b00000;
      pulse_tick();
      checks++;
      if (spawn_req !== (i == 11)) begin
        failures++;
        $display("FAIL gap11_tick%0d: req=%b, required %b", i, spawn_req, i == 11);
      end
      step();
    end
    checks++;
    if (spawn_kind !== KIND_10011) begin
      failures++;
      $display("FAIL gap11_kind: kind=%0d, required %0d", spawn_kind, KIND_10011);
    end
    spawn_ack = 1'b1;
    step();
    spawn_ack = 1'b0;
    checks++;
    if (spawn_count !== 8'd1 || spawn_req !== 1'b0) begin
      failures++;
      $display("FAIL gap11_ack: count=%0d req=%b, required 1 and 0", spawn_count, spawn_req);
    end
  endtask

  // gap = 8 + 0 - 6 = 2, clamped to 4.
  task automatic test_floor();
    start(5'b00000, 2'd3);
    repeat (3) pulse_tick();
    checks++;
    if (spawn_req !== 1'b0) begin
      failures++;
      $display("FAIL floor_early: req=%b after 3 ticks, required 0", spawn_req);
    end
    pulse_tick();
    checks++;
    if (spawn_req !== 1'b1 || spawn_kind !== 2'd0) begin
      failures++;
      $display("FAIL floor_req: req=%b kind=%0d after 4 ticks, required 1 and 0",
               spawn_req, spawn_kind);
    end
  endtask

  // gap = 8 + 1 - 4 = 5, kind TALL; then a 20-tick hold, ack+tick together,
  // reload with gap = 8 + 6 - 2 = 12, kind DOUBLE while ack is held in WAIT.
  task automatic test_hold_ack();
    logic stable;
    start(5'b00001, 2'd2);
    repeat (5) pulse_tick();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pulse_tick();
      if (spawn_req !== 1'b1 || spawn_kind !== 2'd1 || spawn_count !== 8'd0) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL hold_stable: req=%b kind=%0d count=%0d, required 1, 1, 0",
               spawn_req, spawn_kind, spawn_count);
    end
    spawn_ack = 1'b1; tick = 1'b1; rnd = 5'b10110; level = 2'd1;
    step();
    tick = 1'b0;
    checks++;
    if (spawn_count !== 8'd1 || spawn_req !== 1'b0) begin
      failures++;
      $display("FAIL hold_ack: count=%0d req=%b, required 1 and 0", spawn_count, spawn_req);
    end
    step();
    for (int i = 1; i <= 12; i++) begin
      if (i == 12) spawn_ack = 1'b0;
      pulse_tick();
      checks++;
      if (spawn_req !== (i == 12)) begin
        failures++;
        $display("FAIL reload_tick%0d: req=%b, required %b", i, spawn_req, i == 12);
      end
    end
    checks++;
    if (spawn_kind !== 2'd2 || spawn_count !== 8'd1) begin
      failures++;
      $display("FAIL reload_kind: kind=%0d count=%0d, required 2 and 1", spawn_kind, spawn_count);
    end
  endtask

  task automatic test_pause();
    start(5'b00000, 2'd3);
    repeat (4) pulse_tick();
    spawn_ack = 1'b1; rnd = 5'b10011; level = 2'd0;
    step();
    spawn_ack = 1'b0;
    step();
    repeat (6) pulse_tick();
    run = 1'b0;
    step();
    rnd = 5'b00010;
    repeat (3) pulse_tick();
    checks++;
    if (spawn_req !== 1'b0 || spawn_count !== 8'd1) begin
      failures++;
      $display("FAIL pause_wait: req=%b count=%0d, required 0 and 1", spawn_req, spawn_count);
    end
    run = 1'b1;
    step();
    step();
    repeat (9) pulse_tick();
    checks++;
    if (spawn_req !== 1'b0) begin
      failures++;
      $display("FAIL resume_early: req=%b after 9 ticks, required 0", spawn_req);
    end
    pulse_tick();
    checks++;
    if (spawn_req !== 1'b1 || spawn_kind !== 2'd0) begin
      failures++;
      $display("FAIL resume_req: req=%b kind=%0d, required 1 and 0", spawn_req, spawn_kind);
    end
    run = 1'b0;
    step();
    checks++;
    if (spawn_req !== 1'b0 || spawn_count !== 8'd1) begin
      failures++;
      $display("FAIL abandon: req=%b count=%0d, required 0 and 1", spawn_req, spawn_count);
    end
    run = 1'b1;
    step();
    step();
    repeat (10) pulse_tick();
    run = 1'b0; spawn_ack = 1'b1;
    step();
    spawn_ack = 1'b0;
    repeat (4) step();
    checks++;
    if (spawn_req !== 1'b0 || spawn_count !== 8'd2) begin
      failures++;
      $display("FAIL ack_with_stop: req=%b count=%0d, required 0 and 2", spawn_req, spawn_count);
    end
  endtask

  task automatic test_async_reset();
    start(5'b00001, 2'd2);
    repeat (5) pulse_tick();
    spawn_ack = 1'b1;
    step();
    spawn_ack = 1'b0;
    step();
    repeat (5) pulse_tick();
    checks++;
    if (spawn_req !== 1'b1 || spawn_kind !== 2'd1 || spawn_count !== 8'd1) begin
      failures++;
      $display("FAIL pre_reset: req=%b kind=%0d count=%0d, required 1, 1, 1",
               spawn_req, spawn_kind, spawn_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({spawn_req, spawn_kind, spawn_count} !== 11'd0) begin
      failures++;
      $display("FAIL async_reset: req=%b kind=%0d count=%0d, required all 0",
               spawn_req, spawn_kind, spawn_count);
    end
    #2 rst = 1'b0;
    step();
  endtask

  // gap 4 with tick and ack held high: count k is reached at edge 1+6k.
  task automatic test_saturation();
    rst = 1'b1; run = 1'b0; tick = 1'b0; spawn_ack = 1'b0;
    step();
    rst = 1'b0; rnd = 5'b00000; level = 2'd3; tick = 1'b1; spawn_ack = 1'b1; run = 1'b1;
    repeat (61) step();
    checks++;
    if (spawn_count !== 8'd10) begin
      failures++;
      $display("FAIL count_rate: count=%0d after 61 edges, required 10", spawn_count);
    end
    repeat (1800) step();
    checks++;
    if (spawn_count !== 8'd255) begin
      failures++;
      $display("FAIL saturate: count=%0d after 300 spawns, required 255", spawn_count);
    end
    tick = 1'b0; spawn_ack = 1'b0; run = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_gap_basic();
    test_floor();
    test_hold_ack();
    test_pause();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
